// File: rtl/dmem_hs_pkg.sv
// Shared encodings for the handshaked data memory: load/store selects,
// FSM states and the access-size classification used by the lane logic.
package dmem_hs_pkg;

  localparam logic [2:0] LOAD_SEL_B  = 3'b000;
  localparam logic [2:0] LOAD_SEL_H  = 3'b001;
  localparam logic [2:0] LOAD_SEL_W  = 3'b010;
  localparam logic [2:0] LOAD_SEL_BU = 3'b100;
  localparam logic [2:0] LOAD_SEL_HU = 3'b101;

  localparam logic [1:0] STORE_SEL_B = 2'b00;
  localparam logic [1:0] STORE_SEL_H = 2'b01;
  localparam logic [1:0] STORE_SEL_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  // Unknown load selects read as words; unknown store selects are rejected.
  function automatic size_e access_size(input logic we, input logic [2:0] load_sel,
                                        input logic [1:0] store_sel);
    size_e sz;
    sz = SZ_W;
    if (we) begin
      case (store_sel)
        STORE_SEL_B: sz = SZ_B;
        STORE_SEL_H: sz = SZ_H;
        STORE_SEL_W: sz = SZ_W;
        default:     sz = SZ_BAD;
      endcase
    end else begin
      case (load_sel)
        LOAD_SEL_B, LOAD_SEL_BU: sz = SZ_B;
        LOAD_SEL_H, LOAD_SEL_HU: sz = SZ_H;
        default:                 sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: alignment check, store lane merge into the
// current word, and load lane extract with sign/zero extension.
module dmem_align
  import dmem_hs_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_sel_i,
  input  logic [1:0]  store_sel_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] merged_o,
  output logic [31:0] ld_data_o,
  output logic        align_err_o
);

  size_e       size;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign size      = access_size(we_i, load_sel_i, store_sel_i);
  assign byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = word_i[{addr_lo_i[1], 4'b0000} +: 16];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    align_err_o = 1'b0;
    merged_o    = word_i;
    case (size)
      SZ_B: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_H: begin
        align_err_o = addr_lo_i[0];
        merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SZ_W: begin
        align_err_o = |addr_lo_i;
        merged_o    = wdata_i;
      end
      default: align_err_o = 1'b1;
    endcase
  end

  always_comb begin
    ld_data_o = word_i;
    case (load_sel_i)
      LOAD_SEL_B:  ld_data_o = {{24{byte_lane[7]}}, byte_lane};
      LOAD_SEL_BU: ld_data_o = {24'h0, byte_lane};
      LOAD_SEL_H:  ld_data_o = {{16{half_lane[15]}}, half_lane};
      LOAD_SEL_HU: ld_data_o = {16'h0, half_lane};
      default:     ld_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_hs.sv
// Single-outstanding data memory with valid/ready request and response
// channels and a fixed, parameterised response latency.
module dmem_hs
  import dmem_hs_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_sel,
  input  logic [1:0]  req_store_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(LATENCY) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [31:0]     mem_q [MEM_DEPTH];

  logic            accept;
  logic            in_range;
  logic            align_err;
  logic            req_err;
  logic            wr_en;
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [31:0]     merged;
  logic [31:0]     ld_data;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept   = req_valid && req_ready;
  // Range check uses the full word address so high address bits cannot alias.
  assign in_range = (req_addr[31:2] < 30'(MEM_DEPTH));
  assign idx      = req_addr[AW+1:2];
  assign word     = in_range ? mem_q[idx] : 32'h0;
  assign req_err  = align_err || !in_range;
  assign wr_en    = accept && req_we && !req_err;

  dmem_align u_align (
    .we_i        (req_we),
    .addr_lo_i   (req_addr[1:0]),
    .load_sel_i  (req_load_sel),
    .store_sel_i (req_store_sel),
    .wdata_i     (req_wdata),
    .word_i      (word),
    .merged_o    (merged),
    .ld_data_o   (ld_data),
    .align_err_o (align_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req_we || req_err) ? 32'h0 : ld_data;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array must read as all-zero after reset, so it is built from
  // resettable flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

endmodule
